prga_fifo_wr_adapter: RTL and testbench
=======================================

Name: prga_fifo_wr_adapter

Overview:
Producer-side adapter for the write port of `prga_fifo`. It converts an upstream valid/ready stream into the FIFO's full/wr/din write interface. A 2-entry skid buffer keeps `ready_o` a pure register output, which cuts the combinational path from FIFO `full` back to the producer. It pairs with `prga_fifo_lookahead_buffer`, which adapts the read port.

Parameters:
DATA_WIDTH, 8, width of data_i / din.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
valid_i  input  1  upstream word valid
ready_o  output  1  upstream ready; registered, no combinational input dependency
data_i  input  DATA_WIDTH  upstream word
full  input  1  FIFO full (from prga_fifo write port)
wr  output  1  FIFO write request; registered
din  output  DATA_WIDTH  FIFO write data; registered
stat_words  output  32  accepted FIFO writes (only with PRGA_FIFO_WR_ADAPTER_STATS_EN)
stat_stall  output  32  cycles with wr && full (only with PRGA_FIFO_WR_ADAPTER_STATS_EN)

Behaviour:
- Clocking: reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Handshakes:
  - Upstream accept: up = valid_i && ready_o at posedge.
  - Downstream accept: dn = wr && !full at posedge, matching the prga_fifo write semantics.
- Storage: main register (drives din) and skid register. State register: EMPTY / ONE / TWO.
- Outputs by state:
  - wr = (state != EMPTY).
  - din = main.
  - ready_o is a register loaded with (next_state != TWO).
- Transitions:
  - EMPTY: up -> ONE, main <= data_i.
  - ONE, up && !dn -> TWO, skid <= data_i.
  - ONE, !up && dn -> EMPTY.
  - ONE, up && dn -> ONE, main <= data_i.
  - ONE, neither -> hold.
  - TWO, dn -> ONE, main <= skid.
  - TWO, !dn -> hold. up cannot occur in TWO because ready_o = 0.
- Latency: a word accepted at edge N drives wr/din from edge N (visible in cycle N+1). It can be written to the FIFO at edge N+1 at the earliest.
- Throughput: 1 word/cycle sustained while full = 0.
- Ordering: strict FIFO order; no loss or duplication under any full/valid pattern.
- Hold rules:
  - din and wr stay stable while wr && full.
  - data_i is ignored when !ready_o.
  - valid_i may be dropped at any time without a protocol violation.
- Reset values: state = EMPTY, wr = 0, ready_o = 0. din value is don't-care but driven to 0.
  - ready_o rises to 1 on the first posedge after rst deasserts.
- Reset mid-operation: buffered words (up to 2) are discarded. wr = 0 the cycle after the reset edge.
- full while EMPTY is ignored.
- full glitching between cycles is irrelevant; only the posedge sample matters.

Optional Feature:
PRGA_FIFO_WR_ADAPTER_STATS_EN:
- When defined:
  - stat_words and stat_stall ports exist. Both are 32-bit counters, reset to 0.
  - stat_words increments on each dn.
  - stat_stall increments each cycle with wr && full.
  - Both counters saturate at 32'hFFFFFFFF and do not wrap.
- When undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Streaming with full = 0: after reset, stream 5A,F6,09,C4 back-to-back with valid_i = 1 -> ready_o stays 1. wr is high for 4 consecutive cycles starting one cycle after the first accept. din sequence is 5A,F6,09,C4.
- Backpressure: stream 81,E2,A0,7A with full = 1 from the second write cycle for 4 cycles -> ready_o falls after 2 words are buffered, din holds 81 while full. After full drops, the FIFO receives 81,E2,A0,7A in order with no loss.
- Random traffic against prga_fifo: adapter drives a real prga_fifo, with random valid_i (50%) and random FIFO rd (50%) over 1024 words -> the FIFO read-side sequence equals the source sequence. ready_o never depends combinationally on full (checked by toggling full mid-cycle).
- Reset mid-operation: assert rst for one cycle while the adapter is in TWO (wr = 1, full = 1) -> next cycle wr = 0, ready_o = 0. The following cycle ready_o = 1. The two buffered words never appear on din with wr = 1.
- Simultaneous accept in ONE: with state ONE holding 09, apply up and dn in the same cycle with data_i = C4 -> next cycle state is ONE, din = C4, wr = 1, ready_o = 1.
- Stats counters (with PRGA_FIFO_WR_ADAPTER_STATS_EN): scenario 2 -> stat_words = 4, stat_stall = 4. A forced counter preload of FFFFFFFE followed by 3 writes -> stat_words = FFFFFFFF.

Source files
------------

// File: rtl/prga_fifo_wr_adapter_if.sv
// Write-side bundle between an upstream valid/ready producer and the prga_fifo write port.
// The adapter connects through 'slave'; the environment (producer + FIFO) connects through 'master'.
interface prga_fifo_wr_adapter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  full;
    logic                  wr;
    logic [DATA_WIDTH-1:0] din;

    modport slave (
        input  valid_i,
        input  data_i,
        input  full,
        output ready_o,
        output wr,
        output din
    );

    modport master (
        output valid_i,
        output data_i,
        output full,
        input  ready_o,
        input  wr,
        input  din
    );
endinterface

// File: rtl/prga_fifo_wr_adapter.sv
// Producer-side adapter for the prga_fifo write port: a 2-entry skid buffer with fully registered ready_o/wr/din.
// Optional counters stat_words/stat_stall are built when PRGA_FIFO_WR_ADAPTER_STATS_EN is defined.
module prga_fifo_wr_adapter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    prga_fifo_wr_adapter_if.slave  bus
`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
    ,
    output logic [31:0]            stat_words,
    output logic [31:0]            stat_stall
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  ready_reg;
    logic                  wr_reg;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  up;
    logic                  dn;
    logic                  load_main;
    logic                  main_from_skid;
    logic                  load_skid;

    assign up = bus.valid_i && ready_reg;
    assign dn = wr_reg && !bus.full;

    assign bus.ready_o = ready_reg;
    assign bus.wr      = wr_reg;
    assign bus.din     = main_data;

    // wr and ready_o are reloaded from next_state, so they mirror the buffer occupancy one edge ahead
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            wr_reg    <= 1'b0;
            ready_reg <= 1'b0;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= next_state;
            wr_reg    <= (next_state != EMPTY);
            ready_reg <= (next_state != TWO);
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : bus.data_i;
            end
            if (load_skid) begin
                skid_data <= bus.data_i;
            end
        end
    end

    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (up) begin
                    next_state = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (up && !dn) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end else if (!up && dn) begin
                    next_state = EMPTY;
                end else if (up && dn) begin
                    load_main  = 1'b1;
                end
            end
            TWO: begin
                // ready_o is low here, so only the downstream side can move
                if (dn) begin
                    next_state     = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (dn && (stat_words != 32'hFFFF_FFFF)) begin
                stat_words <= stat_words + 32'd1;
            end
            if (wr_reg && bus.full && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prga_fifo_wr_adapter.sv
// Directed self-checking bench for prga_fifo_wr_adapter; the FIFO side is modelled by a queue of accepted writes.
module tb_prga_fifo_wr_adapter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [7:0] received[$];

`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_stall;
`endif

    prga_fifo_wr_adapter_if #(.DATA_WIDTH(8)) bus ();

    prga_fifo_wr_adapter #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave)
`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One clock: log what the FIFO accepts at this edge, then move to 1 time unit past the edge
    task automatic tick();
        if (bus.wr && !bus.full) received.push_back(bus.din);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.full    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        received.delete();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i  = 8'hFF;
        bus.full    = 1'b0;
        tick();
        tests_run += 3;
        if (bus.wr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wr: got %b, expected 0", bus.wr);
        end
        if (bus.ready_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b, expected 0", bus.ready_o);
        end
        if (bus.din !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_din: got %h, expected 00", bus.din);
        end
        tick();
        rst = 1'b0;
        tick();
        tests_run += 2;
        if (bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready_rise: got %b, expected 1", bus.ready_o);
        end
        if (bus.wr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wr_after: got %b, expected 0", bus.wr);
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] words [4] = '{8'h5A, 8'hF6, 8'h09, 8'hC4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = words[i];
            tick();
            tests_run++;
            if (bus.wr !== 1'b1 || bus.din !== words[i] || bus.ready_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_word%0d: got wr=%b din=%h ready=%b, expected wr=1 din=%h ready=1",
                         i, bus.wr, bus.din, bus.ready_o, words[i]);
            end
        end
        bus.valid_i = 1'b0;
        tick();
        tests_run++;
        if (bus.wr !== 1'b0 || received.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL stream_end: got wr=%b writes=%0d, expected wr=0 writes=4", bus.wr, received.size());
        end
    endtask

    task automatic test_backpressure();
        logic       tv   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] td   [9] = '{8'h81, 8'hE2, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h7A, 8'h00};
        logic       tf   [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
        logic       ewr  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0] edin [9] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hE2, 8'hA0, 8'h7A, 8'h00};
        logic       erdy [9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
        logic [7:0] order [4] = '{8'h81, 8'hE2, 8'hA0, 8'h7A};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.valid_i = tv[i];
            bus.data_i  = td[i];
            bus.full    = tf[i];
            tick();
            tests_run++;
            if (bus.wr !== ewr[i] || bus.ready_o !== erdy[i] || (ewr[i] && bus.din !== edin[i])) begin
                tests_failed++;
                $display("[TB] FAIL bp_cycle%0d: got wr=%b din=%h ready=%b, expected wr=%b din=%h ready=%b",
                         i, bus.wr, bus.din, bus.ready_o, ewr[i], edin[i], erdy[i]);
            end
        end
        tests_run++;
        if (received.size() != 4) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: got %0d writes, expected 4", received.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (received[i] !== order[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_order%0d: got %h, expected %h", i, received[i], order[i]);
                end
            end
        end
`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
        tests_run += 2;
        if (stat_words !== 32'd4) begin
            tests_failed++;
            $display("[TB] FAIL stat_words: got %0d, expected 4", stat_words);
        end
        if (stat_stall !== 32'd4) begin
            tests_failed++;
            $display("[TB] FAIL stat_stall: got %0d, expected 4", stat_stall);
        end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h09;
        tick();
        tests_run++;
        if (bus.wr !== 1'b1 || bus.din !== 8'h09) begin
            tests_failed++;
            $display("[TB] FAIL simul_one: got wr=%b din=%h, expected wr=1 din=09", bus.wr, bus.din);
        end
        bus.data_i = 8'hC4;
        tick();
        tests_run++;
        if (bus.wr !== 1'b1 || bus.din !== 8'hC4 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL simul_accept: got wr=%b din=%h ready=%b, expected wr=1 din=c4 ready=1",
                     bus.wr, bus.din, bus.ready_o);
        end
        bus.valid_i = 1'b0;
        bus.full    = 1'b1;
        tick();
        tests_run++;
        if (bus.wr !== 1'b1 || bus.din !== 8'hC4 || bus.ready_o !== 1'b1 || received.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL simul_hold: got wr=%b din=%h ready=%b writes=%0d, expected wr=1 din=c4 ready=1 writes=1",
                     bus.wr, bus.din, bus.ready_o, received.size());
        end
        bus.full = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.valid_i = 1'b1;
        bus.data_i  = 8'h11;
        tick();
        bus.data_i = 8'h22;
        bus.full   = 1'b1;
        tick();
        tests_run++;
        if (bus.wr !== 1'b1 || bus.ready_o !== 1'b0 || bus.din !== 8'h11) begin
            tests_failed++;
            $display("[TB] FAIL midrst_two: got wr=%b ready=%b din=%h, expected wr=1 ready=0 din=11",
                     bus.wr, bus.ready_o, bus.din);
        end
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        tick();
        tests_run++;
        if (bus.wr !== 1'b0 || bus.ready_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_clear: got wr=%b ready=%b, expected wr=0 ready=0", bus.wr, bus.ready_o);
        end
        rst      = 1'b0;
        bus.full = 1'b0;
        tick();
        tests_run++;
        if (bus.wr !== 1'b0 || bus.ready_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_ready: got wr=%b ready=%b, expected wr=0 ready=1", bus.wr, bus.ready_o);
        end
        tick();
        tests_run++;
        if (bus.wr !== 1'b0 || received.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_discard: got wr=%b writes=%0d, expected wr=0 writes=0", bus.wr, received.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] src[$];
        logic       r0;
        logic       prev_stall;
        logic [7:0] prev_din;
        int         accepted = 0;
        int         cycles   = 0;
        do_reset();
        while (accepted < 1024 && cycles < 20000) begin
            bus.valid_i = 1'($urandom_range(0, 1));
            bus.data_i  = 8'($urandom);
            bus.full    = 1'($urandom_range(0, 1));
            r0 = bus.ready_o;
            bus.full = !bus.full;
            #1;
            tests_run++;
            if (bus.ready_o !== r0) begin
                tests_failed++;
                $display("[TB] FAIL rand_ready_comb: got %b, expected %b", bus.ready_o, r0);
            end
            bus.full = !bus.full;
            #1;
            if (bus.valid_i && bus.ready_o) begin
                src.push_back(bus.data_i);
                accepted++;
            end
            prev_stall = bus.wr && bus.full;
            prev_din   = bus.din;
            tick();
            cycles++;
            if (prev_stall) begin
                tests_run++;
                if (bus.wr !== 1'b1 || bus.din !== prev_din) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_hold: got wr=%b din=%h, expected wr=1 din=%h", bus.wr, bus.din, prev_din);
                end
            end
        end
        tests_run++;
        if (accepted < 1024) begin
            tests_failed++;
            $display("[TB] FAIL rand_timeout: got %0d accepted, expected 1024", accepted);
        end
        bus.valid_i = 1'b0;
        bus.full    = 1'b0;
        for (int i = 0; i < 10 && bus.wr; i++) tick();
        tests_run++;
        if (received.size() != src.size()) begin
            tests_failed++;
            $display("[TB] FAIL rand_count: got %0d writes, expected %0d", received.size(), src.size());
        end else begin
            for (int i = 0; i < src.size(); i++) begin
                tests_run++;
                if (received[i] !== src[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_order%0d: got %h, expected %h", i, received[i], src[i]);
                end
            end
        end
    endtask

`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
    task automatic test_stats_saturation();
        do_reset();
        force dut.stat_words = 32'hFFFF_FFFE;
        #1;
        release dut.stat_words;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_i = 8'(i);
            tick();
        end
        bus.valid_i = 1'b0;
        tick();
        tests_run++;
        if (stat_words !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL stat_saturate: got %h, expected ffffffff", stat_words);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.valid_i  = 1'b0;
        bus.data_i   = 8'h00;
        bus.full     = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_midop();
        test_random();
`ifdef PRGA_FIFO_WR_ADAPTER_STATS_EN
        test_stats_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
